// File: rtl/data_memory_pkg.sv
// Shared memory definitions: array geometry, latency counter width, access FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_memory_pkg;

    // Default geometry of the core's data RAM: 2**10 words of 32 bits
    localparam int MEMORY_DEPTH  = 10;
    localparam int MEMORY_WIDTH  = 32;

    // Wide enough for LATENCY-2 with LATENCY up to 15
    localparam int LATENCY_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } data_memory_state_t;

endpackage

// File: rtl/data_memory_array.sv
// Word storage with one synchronous read port and one synchronous write port.
// Latency: read data registered one clk after rd_en; write lands on the same edge.
// Backpressure: none; caller pulses the enables only when an access commits.
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = MEMORY_DEPTH,
    parameter int DATA_WIDTH = MEMORY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; samples the old word on a same-address write (read-before-write),
    // and holds its value between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Multicycle data RAM behind memory_access: one request per LATENCY+1 cycles.
// Latency: LATENCY stalled cycles, result visible in the following DONE cycle.
// Backpressure: memory_stall holds the MEM stage; inputs sampled only in IDLE.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = MEMORY_DEPTH,
    parameter int DATA_WIDTH = MEMORY_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memory_read_enable,
    input  logic [ADDR_WIDTH-1:0] memory_read_address,
    input  logic                  memory_write_enable,
    input  logic [ADDR_WIDTH-1:0] memory_write_address,
    input  logic [DATA_WIDTH-1:0] memory_write_data,
    output logic [DATA_WIDTH-1:0] memory_read_data,
    output logic                  memory_stall
);

    // The counter only has LATENCY_CNT_W bits, so the legal range is enforced here
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
            $error("data_memory: LATENCY must be in 1..15");
        end
    endgenerate

    // BUSY lasts LATENCY-1 cycles: counter counts down LATENCY-2..0
    localparam logic [LATENCY_CNT_W-1:0] CNT_INIT =
        (LATENCY >= 2) ? LATENCY_CNT_W'(LATENCY - 2) : '0;

    data_memory_state_t         state_q;
    data_memory_state_t         state_d;
    logic [LATENCY_CNT_W-1:0]   cnt_q;
    logic [LATENCY_CNT_W-1:0]   cnt_d;
    logic                       accept;

    logic                       req_rd_q;
    logic                       req_wr_q;
    logic [ADDR_WIDTH-1:0]      rd_addr_q;
    logic [ADDR_WIDTH-1:0]      wr_addr_q;
    logic [DATA_WIDTH-1:0]      wr_data_q;

    logic                       request;
    logic                       commit;
    logic                       from_idle;
    logic                       arr_rd_en;
    logic [ADDR_WIDTH-1:0]      arr_rd_addr;
    logic                       arr_wr_en;
    logic [ADDR_WIDTH-1:0]      arr_wr_addr;
    logic [DATA_WIDTH-1:0]      arr_wr_data;

    assign request = memory_read_enable | memory_write_enable;

    // Next-state, countdown and stall; stall rises combinationally with the request
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        memory_stall = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    memory_stall = 1'b1;
                    accept       = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                memory_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            memory_stall = 1'b0;
        end
    end

    // State register plus request capture on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_rd_q  <= 1'b0;
            req_wr_q  <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_rd_q  <= memory_read_enable;
                req_wr_q  <= memory_write_enable;
                rd_addr_q <= memory_read_address;
                wr_addr_q <= memory_write_address;
                wr_data_q <= memory_write_data;
            end
        end
    end

    // The array is touched only on the edge entering DONE. With LATENCY==1 that
    // edge is the same one that accepts the request, so the live inputs are used
    // instead of the (not yet loaded) capture registers. Reset suppresses commit,
    // which is what discards an in-flight write.
    assign commit      = (state_d == DONE) && !rst;
    assign from_idle   = (state_q == IDLE);
    assign arr_rd_en   = commit && (from_idle ? memory_read_enable  : req_rd_q);
    assign arr_wr_en   = commit && (from_idle ? memory_write_enable : req_wr_q);
    assign arr_rd_addr = from_idle ? memory_read_address  : rd_addr_q;
    assign arr_wr_addr = from_idle ? memory_write_address : wr_addr_q;
    assign arr_wr_data = from_idle ? memory_write_data    : wr_data_q;

    data_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (arr_rd_en),
        .rd_addr (arr_rd_addr),
        .rd_data (memory_read_data),
        .wr_en   (arr_wr_en),
        .wr_addr (arr_wr_addr),
        .wr_data (arr_wr_data)
    );

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory at LATENCY 1, 2 and 3 (one instance each).
// Latency: n/a.
// Backpressure: driver holds each request until the DUT leaves stall.
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    k;
        logic [DW-1:0] d;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst   [3];
    logic          re    [3];
    logic          we    [3];
    logic [AW-1:0] ra    [3];
    logic [AW-1:0] wa    [3];
    logic [DW-1:0] wd    [3];
    logic [DW-1:0] rd    [3];
    logic          stall [3];

    // Reference: plain per-instance word array and the value the read port should show
    logic [DW-1:0] mem_m   [3][1024];
    logic [DW-1:0] last_rd [3];
    sb_t           sb_q    [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .memory_read_enable(re[0]), .memory_read_address(ra[0]),
        .memory_write_enable(we[0]), .memory_write_address(wa[0]),
        .memory_write_data(wd[0]), .memory_read_data(rd[0]),
        .memory_stall(stall[0]));

    data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(2)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .memory_read_enable(re[1]), .memory_read_address(ra[1]),
        .memory_write_enable(we[1]), .memory_write_address(wa[1]),
        .memory_write_data(wd[1]), .memory_read_data(rd[1]),
        .memory_stall(stall[1]));

    data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(3)) u_dut2 (
        .clk(clk), .rst(rst[2]),
        .memory_read_enable(re[2]), .memory_read_address(ra[2]),
        .memory_write_enable(we[2]), .memory_write_address(wa[2]),
        .memory_write_data(wd[2]), .memory_read_data(rd[2]),
        .memory_stall(stall[2]));

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 15));
        return AW'(1023 - $urandom_range(0, 15));
    endfunction

    // One full access: issue, model it, push expectation, wait out the stall.
    // With scramble set, addresses/data are perturbed during BUSY to prove they are ignored.
    task automatic access(input int k, input bit do_rd, input logic [AW-1:0] a_rd,
                          input bit do_wr, input logic [AW-1:0] a_wr,
                          input logic [DW-1:0] d_wr, input bit scramble);
        int  n;
        bit  done;
        sb_t e;
        @(posedge clk); #1;
        re[k] = do_rd; ra[k] = a_rd;
        we[k] = do_wr; wa[k] = a_wr; wd[k] = d_wr;
        if (do_rd) last_rd[k] = mem_m[k][a_rd];
        if (do_wr) mem_m[k][a_wr] = d_wr;
        e.k = k[1:0];
        e.d = last_rd[k];
        sb_q.push_back(e);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!stall[k]) begin
                done = 1'b1;
            end else begin
                n++;
                if (scramble) begin
                    @(posedge clk); #1;
                    ra[k] = ra[k] + 1'b1;
                    wa[k] = wa[k] + 1'b1;
                    wd[k] = ~wd[k];
                end
            end
        end
        re[k] = 1'b0;
        we[k] = 1'b0;
        checks++;
        if (!done || n != lat_of(k)) begin
            errors++;
            $display("FAIL stall_cycles dut%0d: got %0d stalled (done=%0d), expected %0d",
                     k, n, done, lat_of(k));
        end
    endtask

    // Monitor: a falling stall outside reset marks the DONE cycle; compare read data there
    initial begin : monitor
        logic prev_stall [3];
        sb_t  e;
        for (int k = 0; k < 3; k++) prev_stall[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst[k] && prev_stall[k] && !stall[k]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done dut%0d: rd=%h with empty scoreboard", k, rd[k]);
                    end else begin
                        e = sb_q.pop_front();
                        if (int'(e.k) != k || rd[k] !== e.d) begin
                            errors++;
                            $display("FAIL read_data dut%0d: got %h, expected %h (queued for dut%0d)",
                                     k, rd[k], e.d, e.k);
                        end
                    end
                end
                prev_stall[k] = stall[k];
            end
        end
    end

    initial begin : stimulus
        logic [AW-1:0] a, b;
        int            op;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; re[k] = 1'b0; we[k] = 1'b0;
            ra[k] = '0; wa[k] = '0; wd[k] = '0;
            last_rd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // Reset state: idle, no stall, read data cleared
        repeat (5) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (stall[k] !== 1'b0 || rd[k] !== '0) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d: stall=%b rd=%h, expected 0/0", k, stall[k], rd[k]);
                end
            end
        end

        // LATENCY=2: write then read back
        access(1, 0, '0, 1, 10'h005, 32'hDEADBEEF, 0);
        access(1, 1, 10'h005, 0, '0, '0, 0);

        // LATENCY=1: back-to-back reads of preloaded words
        access(0, 0, '0, 1, 10'h001, 32'h11, 0);
        access(0, 0, '0, 1, 10'h002, 32'h22, 0);
        access(0, 1, 10'h001, 0, '0, '0, 0);
        access(0, 1, 10'h002, 0, '0, '0, 0);

        // Combined read+write to the same word returns the old contents
        access(1, 0, '0, 1, 10'h003, 32'hAAAA0000, 0);
        access(1, 1, 10'h003, 1, 10'h003, 32'h12345678, 0);
        access(1, 1, 10'h003, 0, '0, '0, 0);

        // Address change during BUSY is ignored (0x009 -> 0x00A)
        access(1, 0, '0, 1, 10'h009, 32'h99990009, 0);
        access(1, 0, '0, 1, 10'h00A, 32'hAAAA000A, 0);
        access(1, 1, 10'h009, 0, '0, '0, 1);

        // LATENCY=3: reset in BUSY discards the in-flight write
        access(2, 0, '0, 1, 10'h007, 32'h0, 0);
        @(posedge clk); #1;
        we[2] = 1'b1; wa[2] = 10'h007; wd[2] = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (stall[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_req_stall: stall=%b, expected 1", stall[2]);
        end
        @(posedge clk); #1;
        rst[2] = 1'b1; we[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (stall[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst_stall: stall=%b, expected 0", stall[2]);
        end
        @(posedge clk); #1;
        rst[2] = 1'b0;
        last_rd[2] = '0;
        @(negedge clk);
        checks++;
        if (stall[2] !== 1'b0 || rd[2] !== '0) begin
            errors++;
            $display("FAIL abort_idle: stall=%b rd=%h, expected 0/0", stall[2], rd[2]);
        end
        access(2, 1, 10'h007, 0, '0, '0, 0);

        // Randomised traffic on every instance over a preloaded address pool
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                access(k, 0, '0, 1, AW'(i), $urandom, i[0]);
                access(k, 0, '0, 1, AW'(1023 - i), $urandom, 0);
            end
            for (int i = 0; i < 30; i++) begin
                op = $urandom_range(0, 2);
                a  = rand_addr();
                b  = ($urandom_range(0, 3) == 0) ? a : rand_addr();
                access(k, op != 1, a, op != 0, b, $urandom, $urandom_range(0, 1) == 1);
            end
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data RAM with configurable access latency. It sits directly downstream of memory_access and consumes that block's read/write address, write data and write enable.
- Returns memory_read_data to memory_access.
- Asserts memory_stall so the pipeline holds the MEM stage while an access is in flight.
- Its purpose is to model multicycle memory; it lets the core's stall path be exercised before a real bus is attached.

Parameters:
- ADDR_WIDTH, default `MEMORY_DEPTH (10): word address width. The array holds 2**ADDR_WIDTH words.
- DATA_WIDTH, default `MEMORY_WIDTH (32): word width.
- LATENCY, default 2: stall cycles per access. Legal range is 1..15; anything outside it is a static elaboration error.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- memory_read_enable  input  1: load request, driven from the OR of the lb/lh/lw/lbu/lhu decodes.
- memory_read_address  input  ADDR_WIDTH: word address for a load.
- memory_write_enable  input  1: store request, from memory_access.
- memory_write_address  input  ADDR_WIDTH: word address for a store.
- memory_write_data  input  DATA_WIDTH: full word to store; byte merging is done by memory_access.
- memory_read_data  output  DATA_WIDTH: load result, valid in the DONE cycle.
- memory_stall  output  1: high while an access is pending; the pipeline holds its inputs stable.

Behaviour:
- Reset state: FSM = IDLE, counter = 0, memory_read_data = 0, memory_stall = 0.
- rst forces memory_stall low combinationally.
- Array contents are not reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE with a request (read_enable or write_enable high):
  - memory_stall = 1 in the same cycle (combinational).
  - Latch addresses, data and request type.
  - If LATENCY == 1, next state is DONE; otherwise next state is BUSY with counter = LATENCY-2.
- IDLE with no request: memory_stall = 0; remain in IDLE.
- BUSY: memory_stall = 1.
  - If counter == 0, go to DONE; otherwise decrement the counter.
- Commit happens on the edge entering DONE:
  - Read: memory_read_data <= array[latched read address].
  - Write: array[latched write address] <= latched data.
- DONE: memory_stall = 0 and the pipeline advances. Next state is IDLE unconditionally.
- Latency summary: one access occupies LATENCY+1 cycles, with exactly LATENCY of them stalled.
  - A back-to-back request is accepted in the cycle after DONE.
  - Minimum spacing between requests is LATENCY+1 cycles.
- memory_read_data holds its value until the next read commit. Writes and idle cycles do not change it.
- Inputs are sampled only in IDLE. Changes during BUSY or DONE are ignored.
- Simultaneous read and write in one request:
  - The read returns the pre-write contents of its address.
  - The write still commits.
  - This applies even when both addresses are equal.
- A read in the DONE cycle of a preceding write to the same address, accepted on the following IDLE, sees the new data.
- Reset asserted mid-access (BUSY or DONE): the FSM returns to IDLE next edge. A pending write that has not yet reached the DONE edge is discarded; a completed one stays.
- No out-of-range addresses exist, because the address width exactly matches the array.

Decomposition:
- Shared package (core defines package) holds:
  - the enum data_memory_state_t {IDLE, BUSY, DONE};
  - localparam LATENCY_CNT_W = 4;
  - the existing MEMORY_DEPTH and MEMORY_WIDTH constants.
- Sub-module data_memory_array: 2**ADDR_WIDTH x DATA_WIDTH storage.
  - One synchronous write port and one synchronous read port, both registered on clk.
  - Read-before-write on address collision.
  - The FSM wrapper drives its enables only on the DONE-entry edge.

Test Plan:
- Reset, then idle for 5 cycles -> memory_stall = 0 and memory_read_data = 0 throughout.
- Write 0xDEADBEEF to address 0x005 with LATENCY=2 -> memory_stall high for exactly 2 cycles, low in the 3rd. Then read address 0x005 -> stall 2 cycles, memory_read_data = 0xDEADBEEF in the DONE cycle.
- LATENCY=1 build: back-to-back reads of addresses 0x001 then 0x002, preloaded with 0x11 and 0x22 -> stall pattern 1,0,1,0; data 0x11 then 0x22.
- Combined request: read and write both to address 0x003, old value 0xAAAA0000, write 0x12345678 -> read returns 0xAAAA0000. A subsequent read returns 0x12345678.
- Write of 0xCAFEF00D to address 0x007 (old value 0x0) with rst pulsed in the BUSY cycle, LATENCY=3 -> next cycle is IDLE with stall 0; a later read of 0x007 returns 0x0.
- Change memory_read_address from 0x009 to 0x00A during BUSY -> the returned data is from 0x009.
